serial_pkt_ctrl: RTL and testbench

- Framing controller downstream of the UART byte receiver.
- Consumes the receiver's byte stream (`rx_data` / `rx_new` strobe) and hunts for a sync byte.
- Assembles a fixed-length payload, checks an XOR checksum, then presents the payload to the miner core as one wide word with a single-cycle valid pulse.
- Enforces an inter-byte timeout so a truncated frame cannot wedge the link.

---
 rtl/serial_pkt_ctrl.sv | 164 ++++++++++++++++
 tb/tb_serial_pkt_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serial_pkt_ctrl.sv
// Sync-hunting framer: collects PAYLOAD_BYTES after SYNC_BYTE, checks the XOR checksum and publishes the payload with a one-cycle pulse.
// Optional macro SERIAL_PKT_STATS_EN adds saturating pkt_count/err_count outputs.
module serial_pkt_ctrl #(
  parameter int         PAYLOAD_BYTES  = 64,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 500000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_new,
  output logic [8*PAYLOAD_BYTES-1:0] payload,
  output logic                       payload_valid,
  output logic                       crc_err,
  output logic                       timeout_err,
  output logic                       busy
`ifdef SERIAL_PKT_STATS_EN
  ,
  output logic [15:0]                pkt_count,
  output logic [15:0]                err_count
`endif
);

  localparam int PW = 8 * PAYLOAD_BYTES;
  localparam int IW = $clog2(PAYLOAD_BYTES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] LAST_IDX  = IW'(PAYLOAD_BYTES - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RECV, CHK} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_shadow;
  logic [PW-1:0] r_payload;
  logic [IW-1:0] r_idx;
  logic [7:0]    r_chk;
  logic [TW-1:0] r_timer;
  logic          r_payload_valid;
  logic          r_crc_err;
  logic          r_timeout_err;

  logic w_start;
  logic w_store;
  logic w_good;
  logic w_bad;
  logic w_tmo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A byte arriving on the last timer tick always beats the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_store     = 1'b0;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_new && (rx_data == SYNC_BYTE)) begin
          w_start     = 1'b1;
          w_state_nxt = RECV;
        end
      end
      RECV: begin
        if (rx_new) begin
          w_store = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = CHK;
          end
        end else if (r_timer == LAST_TICK) begin
          w_tmo       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      CHK: begin
        if (rx_new) begin
          if (rx_data == r_chk) begin
            w_good = 1'b1;
          end else begin
            w_bad = 1'b1;
          end
          w_state_nxt = IDLE;
        end else if (r_timer == LAST_TICK) begin
          w_tmo       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Shifting in from the LSB leaves the first payload byte in the MSB slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow        <= '0;
      r_payload       <= '0;
      r_idx           <= '0;
      r_chk           <= '0;
      r_timer         <= '0;
      r_payload_valid <= 1'b0;
      r_crc_err       <= 1'b0;
      r_timeout_err   <= 1'b0;
    end else begin
      r_payload_valid <= w_good;
      r_crc_err       <= w_bad;
      r_timeout_err   <= w_tmo;
      if (w_good) begin
        r_payload <= r_shadow;
      end
      if (w_start) begin
        r_idx <= '0;
        r_chk <= '0;
      end else if (w_store) begin
        r_shadow <= {r_shadow[PW-9:0], rx_data};
        r_chk    <= r_chk ^ rx_data;
        r_idx    <= r_idx + 1'b1;
      end
      if ((r_state == IDLE) || rx_new || w_tmo) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  assign payload       = r_payload;
  assign payload_valid = r_payload_valid;
  assign crc_err       = r_crc_err;
  assign timeout_err   = r_timeout_err;
  assign busy          = (r_state != IDLE);

`ifdef SERIAL_PKT_STATS_EN
  logic [15:0] r_pkt_count;
  logic [15:0] r_err_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_count <= '0;
      r_err_count <= '0;
    end else begin
      if (w_good && (r_pkt_count != 16'hFFFF)) begin
        r_pkt_count <= r_pkt_count + 1'b1;
      end
      if ((w_bad || w_tmo) && (r_err_count != 16'hFFFF)) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  assign pkt_count = r_pkt_count;
  assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_serial_pkt_ctrl.sv
// Directed bench for serial_pkt_ctrl with PAYLOAD_BYTES=4, TIMEOUT_CYCLES=100.
module tb_serial_pkt_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_new;
  logic [31:0] payload;
  logic        payload_valid;
  logic        crc_err;
  logic        timeout_err;
  logic        busy;
`ifdef SERIAL_PKT_STATS_EN
  logic [15:0] pkt_count;
  logic [15:0] err_count;
`endif

  int checks   = 0;
  int failures = 0;

  serial_pkt_ctrl #(
    .PAYLOAD_BYTES (4),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_new       (rx_new),
    .payload      (payload),
    .payload_valid(payload_valid),
    .crc_err      (crc_err),
    .timeout_err  (timeout_err),
    .busy         (busy)
`ifdef SERIAL_PKT_STATS_EN
    ,
    .pkt_count    (pkt_count),
    .err_count    (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; returns at the next negedge with the byte consumed.
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_new  = 1'b1;
    @(negedge clk);
    rx_new  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] c);
    send(8'hA5); send(b0); send(b1); send(b2); send(b3); send(c);
  endtask

  initial begin
    rst     = 1'b1;
    rx_data = 8'h00;
    rx_new  = 1'b0;
    idle(2);
    chk("reset_payload", payload, 32'h0);
    chk("reset_valid", {31'b0, payload_valid}, 32'h0);
    chk("reset_crc", {31'b0, crc_err}, 32'h0);
    chk("reset_tmo", {31'b0, timeout_err}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;
    idle(1);

    // Good frame with gaps between bytes
    send(8'hA5);
    chk("sync_busy", {31'b0, busy}, 32'h1);
    send(8'h11); idle(2); send(8'h22); send(8'h33); idle(1); send(8'h44);
    chk("pre_chk_valid", {31'b0, payload_valid}, 32'h0);
    send(8'h44);
    chk("good_valid", {31'b0, payload_valid}, 32'h1);
    chk("good_payload", payload, 32'h11223344);
    chk("good_busy", {31'b0, busy}, 32'h0);
    idle(1);
    chk("good_valid_drop", {31'b0, payload_valid}, 32'h0);

    // Bad checksum keeps old payload, then a good frame is accepted
    frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h00);
    chk("bad_crc", {31'b0, crc_err}, 32'h1);
    chk("bad_valid", {31'b0, payload_valid}, 32'h0);
    chk("bad_payload_hold", payload, 32'h11223344);
    idle(1);
    chk("bad_crc_drop", {31'b0, crc_err}, 32'h0);
    frame(8'h55, 8'h66, 8'h77, 8'h88, 8'hCC);
    chk("after_bad_valid", {31'b0, payload_valid}, 32'h1);
    chk("after_bad_payload", payload, 32'h55667788);
    idle(1);

    // Noise in IDLE, sync values inside the payload
    send(8'h00); send(8'hFF);
    chk("noise_busy", {31'b0, busy}, 32'h0);
    frame(8'hA5, 8'h01, 8'h02, 8'h03, 8'hA5);
    chk("syncdata_valid", {31'b0, payload_valid}, 32'h1);
    chk("syncdata_payload", payload, 32'hA5010203);
    idle(1);

    // Timeout after 100 idle cycles
    send(8'hA5); send(8'h11); send(8'h22);
    idle(99);
    chk("tmo_not_yet", {31'b0, timeout_err}, 32'h0);
    chk("tmo_busy_still", {31'b0, busy}, 32'h1);
    idle(1);
    chk("tmo_pulse", {31'b0, timeout_err}, 32'h1);
    chk("tmo_idle", {31'b0, busy}, 32'h0);
    chk("tmo_payload_hold", payload, 32'hA5010203);
    idle(1);
    chk("tmo_pulse_drop", {31'b0, timeout_err}, 32'h0);

    // Byte at the last timer tick wins
    send(8'hA5); send(8'h11);
    idle(99);
    send(8'h22);
    chk("edge_byte_no_tmo", {31'b0, timeout_err}, 32'h0);
    chk("edge_byte_busy", {31'b0, busy}, 32'h1);
    send(8'h33); send(8'h44); send(8'h44);
    chk("edge_frame_valid", {31'b0, payload_valid}, 32'h1);
    chk("edge_frame_payload", payload, 32'h11223344);

    // Back-to-back frame: six consecutive strobes
    frame(8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22);
    chk("b2b_valid", {31'b0, payload_valid}, 32'h1);
    chk("b2b_payload", payload, 32'hDEADBEEF);
    idle(1);

    // Async reset mid-frame, no clock edge in between
    send(8'hA5); send(8'h01);
    #2 rst = 1'b1;
    #1;
    chk("arst_payload", payload, 32'h0);
    chk("arst_busy", {31'b0, busy}, 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h44);
    chk("no_sync_valid", {31'b0, payload_valid}, 32'h0);
    chk("no_sync_busy", {31'b0, busy}, 32'h0);
    chk("no_sync_payload", payload, 32'h0);

    // Two good, one crc error, one timeout
    frame(8'h01, 8'h02, 8'h04, 8'h08, 8'h0F);
    chk("stats_good1", payload, 32'h01020408);
    frame(8'h10, 8'h20, 8'h40, 8'h80, 8'hF0);
    chk("stats_good2", payload, 32'h10204080);
    frame(8'h10, 8'h20, 8'h40, 8'h80, 8'h00);
    chk("stats_crc", {31'b0, crc_err}, 32'h1);
    send(8'hA5);
    idle(100);
    chk("stats_tmo", {31'b0, timeout_err}, 32'h1);
    idle(1);
`ifdef SERIAL_PKT_STATS_EN
    chk("pkt_count", {16'b0, pkt_count}, 32'd2);
    chk("err_count", {16'b0, err_count}, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
